// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage controller. It drives the PC register's
// load port, runs the req/ack handshake with instruction memory, fills the
// IF/ID register and absorbs downstream stalls with a one-entry skid buffer.
// Latency: an instruction reaches IF/ID on the edge after its ack, so a
// zero-wait memory sustains one instruction per cycle.
// Backpressure: a stall together with an ack parks the response in the skid
// buffer (HOLD). No new request is issued until the skid drains into IF/ID.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   pc_value              current PC from the PC register
//   pc_next, pc_enable    PC register data / load enable (combinational)
//   imem_req, imem_addr   fetch request and address, held until imem_ack
//   imem_ack, imem_rdata  memory response and instruction word
//   stall                 ID stage cannot accept the IF/ID entry this cycle
//   redirect,
//   redirect_target       taken branch/jump and its new PC
//   if_valid, if_instr,
//   if_pc_plus4           IF/ID register contents
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_value,
  output logic [31:0] pc_next,
  output logic        pc_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        req_raw;
  logic        pc_en_raw;
  logic [31:0] pc_next_raw;
  logic [31:0] addr_raw;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4  = pc_value + 32'd4;
  assign slot_free = !if_valid_q || !stall;

  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    drop_addr_d  = drop_addr_q;
    req_raw      = 1'b1;
    pc_en_raw    = 1'b0;
    pc_next_raw  = pc_plus4;
    addr_raw     = pc_value;

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if_valid_d  = 1'b0;
          pc_next_raw = redirect_target;
          pc_en_raw   = 1'b1;
          // The wrong-path request is still in flight; remember its address
          // so the request stays stable until memory answers it.
          if (!imem_ack) begin
            drop_addr_d = pc_value;
            state_d     = ST_DROP;
          end
        end else if (imem_ack) begin
          pc_en_raw = 1'b1;
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc4_d   = pc_plus4;
          end else begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = ST_HOLD;
          end
        end else if (if_valid_q && !stall) begin
          if_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        // PC already advanced when the skid was loaded, so no request and
        // no PC load here unless a redirect flushes everything.
        req_raw = 1'b0;
        if (redirect) begin
          if_valid_d  = 1'b0;
          skid_vld_d  = 1'b0;
          pc_next_raw = redirect_target;
          pc_en_raw   = 1'b1;
          state_d     = ST_FETCH;
        end else if (!stall) begin
          if_valid_d = skid_vld_q;
          if_instr_d = skid_instr_q;
          if_pc4_d   = skid_pc4_q;
          skid_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      ST_DROP: begin
        addr_raw   = drop_addr_q;
        if_valid_d = 1'b0;
        if (redirect) begin
          pc_next_raw = redirect_target;
          pc_en_raw   = 1'b1;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d    = ST_FETCH;
        if_valid_d = 1'b0;
        skid_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      if_valid_q   <= 1'b0;
      if_instr_q   <= 32'd0;
      if_pc4_q     <= 32'd0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      drop_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      drop_addr_q  <= drop_addr_d;
    end
  end

  // Request and PC load are gated by reset directly so they drop the moment
  // reset asserts, abandoning any outstanding transaction.
  assign imem_req    = req_raw & reset;
  assign pc_enable   = pc_en_raw & reset;
  assign pc_next     = pc_next_raw;
  assign imem_addr   = addr_raw;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus4 = if_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a model PC register.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked after a further unit, registered outputs 1 unit after each edge.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_value;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;

  logic        pc_load;
  logic [31:0] pc_load_val;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Model of the external PC register.
  always_ff @(posedge clock) begin
    if (pc_load)        pc_value <= pc_load_val;
    else if (pc_enable) pc_value <= pc_next;
  end

  // Memory returns a word derived from the address so each fetch is unique.
  assign imem_rdata = imem_addr ^ KEY;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .pc_value        (pc_value),
    .pc_next         (pc_next),
    .pc_enable       (pc_enable),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc_plus4     (if_pc_plus4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic stl, input logic rd, input logic [31:0] tgt);
    imem_ack        = ack;
    stall           = stl;
    redirect        = rd;
    redirect_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    reset       = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // Reset state
    check("rst_req", imem_req, 1'b0);
    check("rst_pcen", pc_enable, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h0);
    pc_load = 1'b0;
    reset   = 1'b1;

    // Zero-wait stream: addresses 0x0..0x10 on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check("zw_req", imem_req, 1'b1);
      check("zw_addr", imem_addr, 32'(i * 4));
      check("zw_pcen", pc_enable, 1'b1);
      check("zw_pcnext", pc_next, 32'(i * 4 + 4));
      tick();
      check("zw_valid", if_valid, 1'b1);
      check("zw_instr", if_instr, 32'(i * 4) ^ KEY);
      check("zw_pc4", if_pc_plus4, 32'(i * 4 + 4));
    end

    // Stall with ack for 0x14 while IF/ID holds 0x10
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("st_addr", imem_addr, 32'h14);
    check("st_pcen", pc_enable, 1'b1);
    check("st_pcnext", pc_next, 32'h18);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("hold_req", imem_req, 1'b0);
      check("hold_pcen", pc_enable, 1'b0);
      check("hold_instr", if_instr, 32'h10 ^ KEY);
      check("hold_valid", if_valid, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_req", imem_req, 1'b0);
    check("drain_pcen", pc_enable, 1'b0);
    tick();
    check("drain_valid", if_valid, 1'b1);
    check("drain_instr", if_instr, 32'h14 ^ KEY);
    check("drain_pc4", if_pc_plus4, 32'h18);

    // Wait states: two idle cycles then ack for 0x18
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive((i == 2), 1'b0, 1'b0, 32'h0);
      check("ws_req", imem_req, 1'b1);
      check("ws_addr", imem_addr, 32'h18);
      if (pc_enable) pulses++;
      tick();
      check("ws_valid", if_valid, (i == 2));
    end
    check("ws_pulses", 32'(pulses), 32'd1);
    check("ws_instr", if_instr, 32'h18 ^ KEY);
    check("ws_pc4", if_pc_plus4, 32'h1C);

    // One more zero-wait fetch to reach 0x20
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("pre_instr", if_instr, 32'h1C ^ KEY);

    // Redirect with outstanding request for 0x20
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_addr0", imem_addr, 32'h20);
    check("rd_pcen0", pc_enable, 1'b0);
    tick();
    check("rd_valid0", if_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    check("rd_pcen", pc_enable, 1'b1);
    check("rd_pcnext", pc_next, 32'h100);
    tick();
    check("drop_pc", pc_value, 32'h100);
    for (int i = 0; i < 2; i++) begin
      drive((i == 1), 1'b0, 1'b0, 32'h0);
      check("drop_req", imem_req, 1'b1);
      check("drop_addr", imem_addr, 32'h20);
      check("drop_pcen", pc_enable, 1'b0);
      tick();
      check("drop_valid", if_valid, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("tgt_addr", imem_addr, 32'h100);
    tick();
    check("tgt_valid", if_valid, 1'b1);
    check("tgt_instr", if_instr, 32'h100 ^ KEY);
    check("tgt_pc4", if_pc_plus4, 32'h104);

    // Redirect during HOLD, then wrap-around fetch
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("h2_addr", imem_addr, 32'h104);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    check("h2_req", imem_req, 1'b0);
    check("h2_pcen", pc_enable, 1'b1);
    check("h2_pcnext", pc_next, 32'hFFFFFFFC);
    tick();
    check("h2_valid", if_valid, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 32'hFFFFFFFC);
    check("wrap_pcnext", pc_next, 32'h0);
    tick();
    check("wrap_valid", if_valid, 1'b1);
    check("wrap_instr", if_instr, 32'hFFFFFFFC ^ KEY);
    check("wrap_pc4", if_pc_plus4, 32'h0);

    // Reset while in DROP
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rm_addr0", imem_addr, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    check("rm_dropaddr", imem_addr, 32'h4);
    check("rm_pcen_pre", pc_enable, 1'b1);
    reset = 1'b0;
    #1;
    check("rm_req", imem_req, 1'b0);
    check("rm_pcen", pc_enable, 1'b0);
    check("rm_valid", if_valid, 1'b0);
    tick();
    check("rm_pc", pc_value, 32'h200);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("rel_req", imem_req, 1'b1);
    check("rel_addr", imem_addr, 32'h200);
    check("rel_instr", if_instr, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rel_pcnext", pc_next, 32'h204);
    tick();
    check("rel_fetch", if_instr, 32'h200 ^ KEY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
